// File: rtl/mcop_ctrl.sv
// Sequencer for the shared multi-cycle MUL/MULH/DIV/REM unit: start pulse, pipeline stall,
// one-cycle writeback strobe, flush abort and the divide-by-zero shortcut.
module mcop_ctrl #(
    parameter int LAT_MUL = 4,
    parameter int LAT_DIV = 33,
    parameter int CW      = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    input  logic [1:0] req_op,
    input  logic [4:0] req_rd,
    input  logic       div_zero,
    input  logic       flush,
    output logic       unit_start,
    output logic [1:0] unit_op,
    output logic       unit_abort,
    output logic       dz_sel,
    output logic       stall,
    output logic       wb_valid,
    output logic [4:0] wb_rd,
    output logic       busy,
    output logic [1:0] dbg_state
);
    // Handshake: an op is taken when req_valid is high, flush is low and the block is IDLE;
    // the requester sees that acceptance as stall in the same cycle and keeps EX frozen.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    localparam logic [CW-1:0] LOAD_MUL = CW'(LAT_MUL - 1);
    localparam logic [CW-1:0] LOAD_DIV = CW'(LAT_DIV - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    op_q, op_d;
    logic [4:0]    rd_q, rd_d;
    logic          dz_q, dz_d;
    logic          accept;
    logic          dz_in;

    assign accept = (state_q == S_IDLE) && req_valid && !flush;
    assign dz_in  = div_zero & req_op[1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rd_d    = rd_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d = req_op;
                    rd_d = req_rd;
                    dz_d = dz_in;
                    // A zero divisor needs no unit cycles: the result is architectural.
                    if (dz_in) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = req_op[1] ? LOAD_DIV : LOAD_MUL;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Every output, combinational ones included, is held at 0 while reset_n is low.
    always_comb begin
        unit_start = 1'b0;
        unit_op    = '0;
        unit_abort = 1'b0;
        dz_sel     = 1'b0;
        stall      = 1'b0;
        wb_valid   = 1'b0;
        wb_rd      = '0;
        busy       = 1'b0;
        dbg_state  = '0;
        if (reset_n) begin
            dbg_state = state_q;
            case (state_q)
                S_IDLE: begin
                    stall      = accept;
                    unit_start = accept && !dz_in;
                    unit_op    = (accept && !dz_in) ? req_op : 2'b00;
                end
                S_RUN: begin
                    stall      = 1'b1;
                    busy       = 1'b1;
                    unit_abort = flush;
                end
                S_DONE: begin
                    busy     = 1'b1;
                    wb_valid = !flush;
                    wb_rd    = rd_q;
                    dz_sel   = dz_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mcop_ctrl.sv
// Bench for mcop_ctrl: two instances (default latencies and LAT=1/2) against a per-op timeline model.
module tb_mcop_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, req_valid, div_zero, flush;
    logic [1:0] req_op;
    logic [4:0] req_rd;

    logic       d0_start, d0_abort, d0_dz, d0_stall, d0_wv, d0_busy;
    logic [1:0] d0_op, d0_state;
    logic [4:0] d0_rd;
    logic       d1_start, d1_abort, d1_dz, d1_stall, d1_wv, d1_busy;
    logic [1:0] d1_op, d1_state;
    logic [4:0] d1_rd;

    mcop_ctrl u_dut0 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_op(req_op), .req_rd(req_rd),
        .div_zero(div_zero), .flush(flush), .unit_start(d0_start), .unit_op(d0_op),
        .unit_abort(d0_abort), .dz_sel(d0_dz), .stall(d0_stall), .wb_valid(d0_wv),
        .wb_rd(d0_rd), .busy(d0_busy), .dbg_state(d0_state)
    );

    mcop_ctrl #(.LAT_MUL(1), .LAT_DIV(2), .CW(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_op(req_op), .req_rd(req_rd),
        .div_zero(div_zero), .flush(flush), .unit_start(d1_start), .unit_op(d1_op),
        .unit_abort(d1_abort), .dz_sel(d1_dz), .stall(d1_stall), .wb_valid(d1_wv),
        .wb_rd(d1_rd), .busy(d1_busy), .dbg_state(d1_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Timeline model: one in-flight op per instance, described by its writeback cycle.
    int       lat_mul [2] = '{4, 1};
    int       lat_div [2] = '{33, 2};
    bit       m_active[2];
    int       m_wb    [2];
    bit       m_dz    [2];
    logic [4:0] m_rd  [2];

    int start_q[$];
    int wb_q[$];
    int abort_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_dut(input int k, input logic us, input logic [1:0] uo, input logic ua,
                             input logic dzs, input logic st, input logic wv, input logic [4:0] wr,
                             input logic bz, input logic [1:0] ds);
        string p;
        bit acc, e_start, e_abort, e_stall, e_wv, e_busy;
        logic [1:0] e_state;
        p = (k == 0) ? "d0" : "d1";
        acc = req_valid && !flush;
        e_start = 0; e_abort = 0; e_stall = 0; e_wv = 0; e_busy = 0; e_state = 2'd0;
        if (reset_n) begin
            if (!m_active[k]) begin
                e_stall = acc;
                e_start = acc && !(div_zero && req_op[1]);
            end else if (cyc < m_wb[k]) begin
                e_state = 2'd1; e_stall = 1; e_busy = 1; e_abort = flush;
            end else begin
                e_state = 2'd2; e_busy = 1; e_wv = !flush;
            end
        end
        check({p, "_start"}, 32'(us), 32'(e_start));
        check({p, "_abort"}, 32'(ua), 32'(e_abort));
        check({p, "_stall"}, 32'(st), 32'(e_stall));
        check({p, "_wb_valid"}, 32'(wv), 32'(e_wv));
        check({p, "_busy"}, 32'(bz), 32'(e_busy));
        check({p, "_state"}, 32'(ds), 32'(e_state));
        if (e_start) check({p, "_unit_op"}, 32'(uo), 32'(req_op));
        if (e_wv) begin
            check({p, "_wb_rd"}, 32'(wr), 32'(m_rd[k]));
            check({p, "_dz_sel"}, 32'(dzs), 32'(m_dz[k]));
        end
        if (!reset_n) begin
            check({p, "_rst_op"}, 32'(uo), 32'd0);
            check({p, "_rst_rd"}, 32'(wr), 32'd0);
            check({p, "_rst_dz"}, 32'(dzs), 32'd0);
        end
    endtask

    task automatic advance_model();
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                m_active[k] = 0;
            end else if (!m_active[k]) begin
                if (req_valid && !flush) begin
                    m_active[k] = 1;
                    m_dz[k] = div_zero && req_op[1];
                    m_rd[k] = req_rd;
                    m_wb[k] = cyc + (m_dz[k] ? 1 : ((req_op[1] ? lat_div[k] : lat_mul[k]) + 1));
                end
            end else if ((cyc < m_wb[k] && flush) || cyc == m_wb[k]) begin
                m_active[k] = 0;
            end
        end
    endtask

    // Inputs are already driven for this cycle; sample mid-cycle, then step to the next edge.
    task automatic tick();
        #2;
        check_dut(0, d0_start, d0_op, d0_abort, d0_dz, d0_stall, d0_wv, d0_rd, d0_busy, d0_state);
        check_dut(1, d1_start, d1_op, d1_abort, d1_dz, d1_stall, d1_wv, d1_rd, d1_busy, d1_state);
        if (d0_start === 1'b1) start_q.push_back(cyc);
        if (d0_wv === 1'b1) wb_q.push_back(cyc);
        if (d0_abort === 1'b1) abort_q.push_back(cyc);
        advance_model();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_log();
        start_q.delete(); wb_q.delete(); abort_q.delete();
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [4:0] rd, input logic dz,
                         input logic fl);
        req_valid = v; req_op = op; req_rd = rd; div_zero = dz; flush = fl;
    endtask

    int t0;

    initial begin
        reset_n = 1'b0;
        drive(0, 2'd0, 5'd0, 0, 0);
        for (int k = 0; k < 2; k++) begin m_active[k] = 0; m_wb[k] = 0; m_dz[k] = 0; m_rd[k] = 0; end
        tick(); tick();
        reset_n = 1'b1;
        while (cyc < 10) tick();

        // MUL rd=5 accepted at cycle 10, EX holds the request while stalled
        clear_log(); t0 = cyc;
        drive(1, 2'b00, 5'd5, 0, 0);
        repeat (5) tick();
        drive(0, 2'b00, 5'd0, 0, 0);
        repeat (3) tick();
        check("mul_start_cyc", (start_q.size() > 0) ? start_q[0] : -1, t0);
        check("mul_wb_cyc", (wb_q.size() > 0) ? wb_q[0] : -1, t0 + 5);

        // DIV rd=7, full 33-cycle latency
        clear_log(); t0 = cyc;
        drive(1, 2'b10, 5'd7, 0, 0);
        tick();
        drive(0, 2'b00, 5'd0, 0, 0);
        repeat (38) tick();
        check("div_wb_cyc", (wb_q.size() > 0) ? wb_q[0] : -1, t0 + 34);
        check("div_wb_count", wb_q.size(), 1);

        // REM by zero: no unit start, writeback next cycle
        clear_log(); t0 = cyc;
        drive(1, 2'b11, 5'd9, 1, 0);
        tick();
        drive(0, 2'b00, 5'd0, 0, 0);
        repeat (3) tick();
        check("dz_no_start", start_q.size(), 0);
        check("dz_wb_cyc", (wb_q.size() > 0) ? wb_q[0] : -1, t0 + 1);

        // DIV flushed in its third RUN cycle
        clear_log(); t0 = cyc;
        drive(1, 2'b10, 5'd12, 0, 0);
        tick();
        drive(0, 2'b00, 5'd0, 0, 0);
        tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (38) tick();
        check("flush_abort_count", abort_q.size(), 1);
        check("flush_abort_cyc", (abort_q.size() > 0) ? abort_q[0] : -1, t0 + 3);
        check("flush_no_wb", wb_q.size(), 0);

        // request and flush together in IDLE
        clear_log();
        drive(1, 2'b01, 5'd4, 0, 1);
        tick();
        drive(0, 2'b00, 5'd0, 0, 0);
        tick();
        check("same_cyc_flush_start", start_q.size(), 0);

        // reset pulse mid-RUN
        clear_log();
        drive(1, 2'b00, 5'd6, 0, 0);
        tick();
        drive(0, 2'b00, 5'd0, 0, 0);
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (8) tick();
        check("rst_no_wb", wb_q.size(), 0);
        check("rst_no_abort", abort_q.size(), 0);

        // back-to-back MULs with req_valid held high
        clear_log();
        drive(1, 2'b00, 5'd3, 0, 0);
        repeat (14) tick();
        drive(0, 2'b00, 5'd0, 0, 0);
        repeat (6) tick();
        check("b2b_two_starts", 32'(start_q.size() >= 2), 32'd1);
        if (start_q.size() >= 2 && wb_q.size() >= 1) begin
            check("b2b_gap", start_q[1] - wb_q[0], 1);
            check("b2b_period", start_q[1] - start_q[0], 6);
        end

        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            reset_n   = ($urandom_range(0, 199) != 0);
            req_valid = ($urandom_range(0, 9) < 7);
            req_op    = 2'($urandom_range(0, 3));
            req_rd    = 5'($urandom_range(0, 31));
            div_zero  = ($urandom_range(0, 4) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
